// File: rtl/hamming_pkg.sv
// hamming_pkg
// Shared definitions for the Hamming(7,4) encoder, the codeword serializer
// and the future decoder/deserializer.
//   CW_WIDTH    : codeword width in bits
//   FRAME_BITS  : serial frame length (start + codeword + stop)
//   ser_state_t : serializer FSM state encoding
//   CW_*        : bit positions of parity/data bits inside a codeword
package hamming_pkg;

  localparam int CW_WIDTH   = 7;
  localparam int FRAME_BITS = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } ser_state_t;

  // Codeword bit positions: p1 p2 d0 p4 d1 d2 d3 from LSB upward.
  localparam int CW_P1 = 0;
  localparam int CW_P2 = 1;
  localparam int CW_D0 = 2;
  localparam int CW_P4 = 3;
  localparam int CW_D1 = 4;
  localparam int CW_D2 = 5;
  localparam int CW_D3 = 6;

  // Index of the last codeword bit sent in the DATA state.
  localparam logic [2:0] LAST_BIT_IDX = 3'(CW_WIDTH - 1);

endpackage

// File: rtl/hamming_bit_timer.sv
// hamming_bit_timer
// Bit-period counter for the codeword serializer. Counts 0..CLKS_PER_BIT-1
// and asserts tick on the terminal count, then wraps to 0.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (count = 0)
//   clear : synchronous restart of the bit period (count = 0)
//   tick  : high in the last cycle of each bit period
module hamming_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  // A one-cycle bit period still needs a 1-bit counter.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/hamming_cw_serializer.sv
// hamming_cw_serializer
// Sends each accepted 7-bit codeword as a UART-style frame: start bit (0),
// codeword bits LSB first, stop bit (1). A one-entry holding buffer accepts
// the next codeword mid-frame so frames can run back to back.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset; aborts frame, drops buffer
//   cw_in      : codeword (don't-care unless cw_valid)
//   cw_valid   : cw_in holds a codeword
//   cw_ready   : codeword can be accepted this cycle (= buffer empty)
//   tx_out     : serial line, idle high, driven from a flop
//   busy       : frame in progress (START/DATA/STOP)
//   frame_done : pulse in the last cycle of each stop bit
//
// Handshake: a codeword transfers on every rising edge where cw_valid and
// cw_ready are both high; cw_ready depends on registered state only.
import hamming_pkg::*;

module hamming_cw_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW_WIDTH-1:0] cw_in,
  input  logic                cw_valid,
  output logic                cw_ready,
  output logic                tx_out,
  output logic                busy,
  output logic                frame_done
);

  ser_state_t          state;
  ser_state_t          state_next;
  logic [CW_WIDTH-1:0] shift;
  logic [CW_WIDTH-1:0] shift_next;
  logic [CW_WIDTH-1:0] hold_buf;
  logic                buf_full;
  logic [2:0]          bit_idx;
  logic                tick;
  logic                xfer;
  logic                stop_end;
  logic                load_new;
  logic                load_buf;
  logic                buf_write;
  logic                tx_next;

  assign cw_ready = !buf_full;
  assign xfer     = cw_valid && cw_ready;

  hamming_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(load_new || load_buf),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (xfer) state_next = ST_START;
      ST_START: if (tick) state_next = ST_DATA;
      ST_DATA:  if (tick && (bit_idx == LAST_BIT_IDX)) state_next = ST_STOP;
      ST_STOP:  if (tick) state_next = (buf_full || xfer) ? ST_START : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    stop_end   = (state == ST_STOP) && tick;
    busy       = (state != ST_IDLE);
    frame_done = stop_end;
    // A buffered word always wins at frame end; cw_ready is low then, so a
    // direct load from cw_in only happens with the buffer empty.
    load_buf   = stop_end && buf_full;
    load_new   = xfer && ((state == ST_IDLE) || stop_end);
    buf_write  = xfer && (state != ST_IDLE) && !stop_end;

    shift_next = shift;
    if (load_new) begin
      shift_next = cw_in;
    end else if (load_buf) begin
      shift_next = hold_buf;
    end else if ((state == ST_DATA) && tick) begin
      shift_next = shift >> 1;
    end

    // tx_out is registered, so it is driven from the state being entered.
    tx_next = 1'b1;
    case (state_next)
      ST_IDLE:  tx_next = 1'b1;
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shift_next[0];
      ST_STOP:  tx_next = 1'b1;
      default:  tx_next = 1'b1;
    endcase
  end

  // Datapath: shift register, bit index, holding buffer, line flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift    <= '0;
      bit_idx  <= '0;
      hold_buf <= '0;
      buf_full <= 1'b0;
      tx_out   <= 1'b1;
    end else begin
      shift  <= shift_next;
      tx_out <= tx_next;

      if (load_new || load_buf) begin
        bit_idx <= '0;
      end else if ((state == ST_DATA) && tick) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (buf_write) begin
        hold_buf <= cw_in;
        buf_full <= 1'b1;
      end else if (load_buf) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hamming_cw_serializer.sv
// tb_hamming_cw_serializer
// Self-checking bench for hamming_cw_serializer. Accepted codewords are
// queued as expected frames; a monitor watches the line every cycle and
// checks frame contents, bit timing, busy/frame_done/cw_ready and the gap
// (or lack of one) between frames.
`timescale 1ns/1ps
module tb_hamming_cw_serializer;
  import hamming_pkg::*;

  localparam int C = 3;
  localparam int W = CW_WIDTH;

  // Clock / reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] cw_in = '0;
  logic         cw_valid = 1'b0;
  logic         cw_ready;
  logic         tx_out;
  logic         busy;
  logic         frame_done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  hamming_cw_serializer #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cw_in     (cw_in),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .tx_out    (tx_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // Scoreboard state
  int                    tests = 0;
  int                    fails = 0;
  logic [W-1:0]          exp_q[$];
  logic [FRAME_BITS-1:0] cur;
  bit                    in_frame = 1'b0;
  bit                    mon_on = 1'b0;
  int                    b_i = 0;
  int                    k_i = 0;
  int                    frames_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one evaluation per cycle, mid-cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (!in_frame) begin
        // Any accepted, not-yet-started word must start on the line now.
        chk("start_timing", {31'd0, !tx_out}, {31'd0, exp_q.size() != 0});
        if (tx_out === 1'b0 && exp_q.size() != 0) begin
          cur = {1'b1, exp_q.pop_front(), 1'b0};
          in_frame = 1'b1;
          b_i = 0;
          k_i = 0;
          frames_seen++;
        end else begin
          chk("idle_busy", {31'd0, busy}, 32'd0);
          chk("idle_frame_done", {31'd0, frame_done}, 32'd0);
        end
      end
      if (in_frame) begin
        chk($sformatf("tx_bit%0d", b_i), {31'd0, tx_out}, {31'd0, cur[b_i]});
        chk("busy", {31'd0, busy}, 32'd1);
        chk("frame_done", {31'd0, frame_done},
            {31'd0, (b_i == FRAME_BITS - 1) && (k_i == C - 1)});
        if (k_i == C - 1) begin
          k_i = 0;
          b_i++;
          if (b_i == FRAME_BITS) in_frame = 1'b0;
        end else begin
          k_i++;
        end
      end
      // One word may wait behind the frame on the line; more is refused.
      chk("cw_ready", {31'd0, cw_ready}, {31'd0, exp_q.size() == 0});
      if (rst) begin
        exp_q.delete();
        in_frame = 1'b0;
      end else if (cw_valid === 1'b1 && cw_ready === 1'b1) begin
        exp_q.push_back(cw_in);
      end
    end else if (rst) begin
      mon_on = 1'b1;
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    int n = 0;
    cw_in = w;
    cw_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (cw_ready !== 1'b1 && n < 200);
    if (cw_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: cw_ready %b, required 1 within 200 cycles", cw_ready);
    end
    @(posedge clk);
    #1;
    cw_valid = 1'b0;
    cw_in = W'($urandom);
  endtask

  initial begin
    int n;
    idle(3);
    rst = 1'b0;
    idle(3);

    // Single frame: 0,1,0,1,0,1,0,1,1
    send(7'h55);
    idle(9 * C + 4);

    // Three words with valid held: one frame, one buffered, one stalled.
    send(W'($urandom));
    send(W'($urandom));
    send(W'($urandom));
    idle(30 * C);

    // Second word offered exactly in the final stop cycle (bypass load).
    send(7'h2A);
    repeat (9 * C - 1) @(posedge clk);
    #1;
    send(7'h13);
    idle(10 * C);

    // Reset mid-DATA with a word buffered and a transfer attempted.
    send(7'h6C);
    send(7'h35);
    repeat (3 * C) @(posedge clk);
    #1;
    rst = 1'b1;
    cw_valid = 1'b1;
    cw_in = 7'h7F;
    idle(1);
    rst = 1'b0;
    cw_valid = 1'b0;
    idle(12 * C);

    // Reset in idle with a transfer attempted in the reset cycle.
    rst = 1'b1;
    cw_valid = 1'b1;
    cw_in = 7'h41;
    idle(1);
    rst = 1'b0;
    cw_valid = 1'b0;
    idle(4);

    // Random words with random gaps, including zero and near frame end.
    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(0, 11 * C));
      send(W'($urandom));
    end

    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", {31'd0, (exp_q.size() != 0 || in_frame)}, 32'd0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
